// File: rtl/tl_router_param.sv
// rtl/tl_router_param.sv - class-steered router: input FIFO feeding NCH output FIFOs
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   init                  hold in INIT and latch thresholds while high
//   Umbral_bajo/alto      almost-empty / almost-full thresholds
//   push_in, data_in      input FIFO write
//   full_in               input FIFO full
//   pop_out               per-channel read request
//   data_out              per-channel FWFT head, channel c at [c*WIDTH +: WIDTH]
//   empty_out             per-channel empty
//   almost_empty_out      per-channel count <= latched Umbral_bajo
//   req, idx              traffic counter read (idx NCH = input accept counter)
//   counter_out/valid     registered read data and one-cycle qualifier
//   state                 one-hot FSM state
module tl_router_param #(
    parameter int WIDTH   = 12,
    parameter int DEPTH   = 8,
    parameter int NCH     = 4,
    parameter int SEL_LSB = 10,
    parameter int CNT_W   = 5
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       init,
    input  logic [$clog2(DEPTH)-1:0]   Umbral_bajo,
    input  logic [$clog2(DEPTH)-1:0]   Umbral_alto,
    input  logic                       push_in,
    input  logic [WIDTH-1:0]           data_in,
    input  logic [NCH-1:0]             pop_out,
    output logic [NCH*WIDTH-1:0]       data_out,
    output logic [NCH-1:0]             empty_out,
    output logic [NCH-1:0]             almost_empty_out,
    output logic                       full_in,
    input  logic                       req,
    input  logic [$clog2(NCH):0]       idx,
    output logic [CNT_W-1:0]           counter_out,
    output logic                       counter_valid,
    output logic [4:0]                 state
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(NCH);
    localparam int IW = SW + 1;

    typedef enum logic [4:0] {
        S_RESET  = 5'b00001,
        S_INIT   = 5'b00010,
        S_IDLE   = 5'b00100,
        S_ACTIVE = 5'b01000,
        S_ERROR  = 5'b10000
    } state_t;

    state_t state_q, state_d;

    logic [AW-1:0] thr_lo, thr_hi;

    // run: routing and input writes allowed; drain: output pops honoured
    logic run, drain, clr;
    assign run   = (state_q == S_IDLE) || (state_q == S_ACTIVE);
    assign drain = run || (state_q == S_ERROR);
    assign clr   = (state_q == S_INIT);

    // Input FIFO
    logic [WIDTH-1:0] in_mem [DEPTH];
    logic [AW-1:0]    in_wr, in_rd;
    logic [AW:0]      in_cnt;
    logic             in_empty, accept, route;
    logic [SW-1:0]    dest;
    logic [NCH-1:0]   afull, pop_ok;

    assign full_in  = (in_cnt == CW'(DEPTH));
    assign in_empty = (in_cnt == '0);
    assign accept   = run && push_in && !full_in;
    assign dest     = in_mem[in_rd][SEL_LSB +: SW];
    // Head-of-line: a blocked head stalls every channel.
    assign route    = run && !in_empty && !afull[dest];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_wr  <= '0;
            in_rd  <= '0;
            in_cnt <= '0;
        end else if (clr) begin
            in_wr  <= '0;
            in_rd  <= '0;
            in_cnt <= '0;
        end else begin
            if (accept) in_wr <= in_wr + 1'b1;
            if (route)  in_rd <= in_rd + 1'b1;
            case ({accept, route})
                2'b10:   in_cnt <= in_cnt + 1'b1;
                2'b01:   in_cnt <= in_cnt - 1'b1;
                default: in_cnt <= in_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (accept) in_mem[in_wr] <= data_in;
    end

    // Output channels
    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic [WIDTH-1:0] mem [DEPTH];
        logic [AW-1:0]    wr, rd;
        logic [AW:0]      cnt;
        logic             push;

        assign push      = route && (dest == SW'(c));
        assign pop_ok[c] = drain && pop_out[c] && (cnt != '0);
        assign afull[c]  = (cnt >= {1'b0, thr_hi});
        assign empty_out[c]        = (cnt == '0);
        assign almost_empty_out[c] = (cnt <= {1'b0, thr_lo});
        // Masked so the head reads zero whenever the channel is empty.
        assign data_out[c*WIDTH +: WIDTH] = (cnt == '0) ? '0 : mem[rd];

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                wr  <= '0;
                rd  <= '0;
                cnt <= '0;
            end else if (clr) begin
                wr  <= '0;
                rd  <= '0;
                cnt <= '0;
            end else begin
                if (push)      wr <= wr + 1'b1;
                if (pop_ok[c]) rd <= rd + 1'b1;
                case ({push, pop_ok[c]})
                    2'b10:   cnt <= cnt + 1'b1;
                    2'b01:   cnt <= cnt - 1'b1;
                    default: cnt <= cnt;
                endcase
            end
        end

        always_ff @(posedge clk) begin
            if (push) mem[wr] <= in_mem[in_rd];
        end
    end

    // Thresholds
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            thr_lo <= '0;
            thr_hi <= '0;
        end else if (clr) begin
            thr_lo <= Umbral_bajo;
            thr_hi <= Umbral_alto;
        end
    end

    // Traffic counters: 0..NCH-1 channel pops, NCH accepted input pushes
    logic [CNT_W-1:0] ctr [NCH+1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i <= NCH; i++) ctr[i] <= '0;
        end else if (clr) begin
            for (int i = 0; i <= NCH; i++) ctr[i] <= '0;
        end else begin
            for (int i = 0; i < NCH; i++)
                if (pop_ok[i]) ctr[i] <= ctr[i] + 1'b1;
            if (accept) ctr[NCH] <= ctr[NCH] + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            counter_out   <= '0;
            counter_valid <= 1'b0;
        end else begin
            counter_valid <= req && (state_q != S_RESET);
            if (req && (state_q != S_RESET))
                counter_out <= (idx <= IW'(NCH)) ? ctr[idx] : '0;
        end
    end

    // Control FSM
    logic any_data, err;
    assign any_data = !in_empty || !(&empty_out);
    assign err      = run && ((push_in && full_in) || (|(pop_out & empty_out)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_RESET;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RESET: state_d = S_INIT;
            S_INIT:  if (!init) state_d = S_IDLE;
            S_IDLE: begin
                if (init)          state_d = S_INIT;
                else if (err)      state_d = S_ERROR;
                else if (any_data) state_d = S_ACTIVE;
            end
            S_ACTIVE: begin
                if (init)           state_d = S_INIT;
                else if (err)       state_d = S_ERROR;
                else if (!any_data) state_d = S_IDLE;
            end
            S_ERROR: if (init) state_d = S_INIT;
            default: state_d = S_RESET;
        endcase
    end

    assign state = state_q;

endmodule

// File: tb/tb_tl_router_param.sv
// tb/tb_tl_router_param.sv - directed self-checking bench for tl_router_param
module tb_tl_router_param;
    logic        clk = 1'b0;
    logic        reset, init;
    logic [2:0]  Umbral_bajo, Umbral_alto;
    logic        push_in;
    logic [11:0] data_in;
    logic [3:0]  pop_out;
    logic [47:0] data_out;
    logic [3:0]  empty_out, almost_empty_out;
    logic        full_in;
    logic        req;
    logic [2:0]  idx;
    logic [4:0]  counter_out;
    logic        counter_valid;
    logic [4:0]  state;

    int total = 0;
    int bad   = 0;

    localparam logic [4:0] ST_RESET  = 5'b00001;
    localparam logic [4:0] ST_INIT   = 5'b00010;
    localparam logic [4:0] ST_IDLE   = 5'b00100;
    localparam logic [4:0] ST_ACTIVE = 5'b01000;
    localparam logic [4:0] ST_ERROR  = 5'b10000;

    logic [11:0] ch1_words [6];

    tl_router_param dut (
        .clk(clk), .reset(reset), .init(init),
        .Umbral_bajo(Umbral_bajo), .Umbral_alto(Umbral_alto),
        .push_in(push_in), .data_in(data_in), .pop_out(pop_out),
        .data_out(data_out), .empty_out(empty_out),
        .almost_empty_out(almost_empty_out), .full_in(full_in),
        .req(req), .idx(idx), .counter_out(counter_out),
        .counter_valid(counter_valid), .state(state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic read_ctr(input logic [2:0] i);
        req = 1'b1;
        idx = i;
        tick();
        req = 1'b0;
    endtask

    initial begin
        reset = 1'b1; init = 1'b1;
        Umbral_bajo = 3'd1; Umbral_alto = 3'd6;
        push_in = 1'b0; data_in = '0; pop_out = '0; req = 1'b0; idx = '0;
        ch1_words[0] = 12'h411; ch1_words[1] = 12'h412; ch1_words[2] = 12'h413;
        ch1_words[3] = 12'h414; ch1_words[4] = 12'h415; ch1_words[5] = 12'h400;

        // Reset values
        #2;
        check("rst_state", state, ST_RESET);
        check("rst_empty", empty_out, 4'hF);
        check("rst_aempty", almost_empty_out, 4'hF);
        check("rst_full", full_in, 1'b0);
        check("rst_data", data_out, 48'h0);
        check("rst_cnt", counter_out, 5'd0);
        check("rst_valid", counter_valid, 1'b0);
        tick(); tick();
        check("rst_hold", state, ST_RESET);
        reset = 1'b0;
        tick();
        check("to_init", state, ST_INIT);
        tick();
        init = 1'b0;
        tick();
        check("to_idle", state, ST_IDLE);

        // Basic routing
        data_in = 12'h005; push_in = 1'b1; tick();
        data_in = 12'h406; tick();
        data_in = 12'h807; tick();
        data_in = 12'hC08; tick();
        push_in = 1'b0; tick();
        check("basic_data", data_out, 48'hC08_807_406_005);
        check("basic_state", state, ST_ACTIVE);
        check("basic_empty", empty_out, 4'h0);
        check("basic_aempty", almost_empty_out, 4'hF);
        pop_out = 4'hF; tick(); pop_out = 4'h0;
        check("basic_drained", empty_out, 4'hF);
        tick();
        check("basic_idle", state, ST_IDLE);

        // Backpressure: channel 2 stops at 6 entries
        push_in = 1'b1;
        for (int i = 0; i < 8; i++) begin
            data_in = 12'h800 + 12'(i);
            tick();
        end
        push_in = 1'b0; tick();
        check("bp_full", full_in, 1'b0);
        check("bp_empty", empty_out, 4'b1011);
        check("bp_aempty", almost_empty_out, 4'b1011);
        check("bp_head", data_out[35:24], 12'h800);
        pop_out = 4'b0100; tick(); pop_out = 4'h0;
        tick(); tick();
        for (int i = 1; i < 8; i++) begin
            check("bp_order", data_out[35:24], 12'h800 + 12'(i));
            pop_out = 4'b0100; tick();
        end
        pop_out = 4'h0;
        check("bp_drained", empty_out, 4'hF);
        tick();

        // Head-of-line blocking behind a full channel 1
        push_in = 1'b1;
        for (int i = 0; i < 6; i++) begin
            data_in = 12'h410 + 12'(i);
            tick();
        end
        data_in = 12'h400; tick();
        data_in = 12'h001; tick();
        push_in = 1'b0; tick(); tick();
        check("hol_empty", empty_out, 4'b1101);
        check("hol_ch0", data_out[11:0], 12'h000);
        pop_out = 4'b0010; tick(); pop_out = 4'h0;
        tick(); tick();
        check("hol_release", data_out[11:0], 12'h001);
        check("hol_empty2", empty_out, 4'b1100);

        // Overflow: channel 1 blocked, input fills, 9th push dropped
        push_in = 1'b1;
        for (int i = 0; i < 8; i++) begin
            data_in = 12'h420 + 12'(i);
            tick();
        end
        check("ovf_full", full_in, 1'b1);
        check("ovf_pre_state", state, ST_ACTIVE);
        data_in = 12'h428; tick();
        push_in = 1'b0;
        check("ovf_state", state, ST_ERROR);
        for (int i = 0; i < 6; i++) begin
            check("err_drain", data_out[23:12], ch1_words[i]);
            pop_out = 4'b0010; tick();
        end
        pop_out = 4'h0; tick();
        check("err_no_route", empty_out, 4'b1110);
        check("err_sticky", state, ST_ERROR);
        read_ctr(3'd1);
        check("ctr_ch1", counter_out, 5'd8);
        check("ctr_ch1_v", counter_valid, 1'b1);
        read_ctr(3'd4);
        check("ctr_in_dropped", counter_out, 5'd28);
        tick();
        check("ctr_v_low", counter_valid, 1'b0);

        // init clears; Umbral_alto=0 stalls routing without error
        init = 1'b1; Umbral_alto = 3'd0; Umbral_bajo = 3'd2;
        tick(); tick();
        check("init_state", state, ST_INIT);
        check("init_empty", empty_out, 4'hF);
        check("init_full", full_in, 1'b0);
        read_ctr(3'd4);
        check("init_ctr", counter_out, 5'd0);
        check("init_ctr_v", counter_valid, 1'b1);
        init = 1'b0; tick();
        check("init_idle", state, ST_IDLE);
        push_in = 1'b1; data_in = 12'hC01; tick();
        data_in = 12'hC02; tick();
        push_in = 1'b0; tick(); tick();
        check("stall_empty", empty_out, 4'hF);
        check("stall_state", state, ST_ACTIVE);

        // Underflow
        pop_out = 4'b0001; tick(); pop_out = 4'h0;
        check("udf_state", state, ST_ERROR);

        // Counter read
        init = 1'b1; Umbral_alto = 3'd6; Umbral_bajo = 3'd1;
        tick(); tick(); init = 1'b0; tick();
        push_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            data_in = 12'hC00 + 12'(i);
            tick();
        end
        push_in = 1'b0; tick();
        for (int i = 0; i < 3; i++) begin
            pop_out = 4'b1000; tick();
        end
        pop_out = 4'h0;
        check("cr_empty", empty_out, 4'hF);
        req = 1'b1; idx = 3'd3; tick();
        check("cr_idx3", counter_out, 5'd3);
        check("cr_idx3_v", counter_valid, 1'b1);
        idx = 3'd4; tick();
        check("cr_idx4", counter_out, 5'd3);
        idx = 3'd7; tick();
        check("cr_idx7", counter_out, 5'd0);
        check("cr_idx7_v", counter_valid, 1'b1);
        req = 1'b0; tick();
        check("cr_v_low", counter_valid, 1'b0);

        // Counter wrap: 33 accepted pushes round-robin, drained as they arrive
        init = 1'b1; tick(); tick(); init = 1'b0; tick();
        for (int i = 0; i < 33; i++) begin
            push_in = 1'b1;
            data_in = {2'(i % 4), 10'(i)};
            pop_out = ~empty_out;
            tick();
        end
        push_in = 1'b0;
        for (int i = 0; i < 6; i++) begin
            pop_out = ~empty_out;
            tick();
        end
        pop_out = 4'h0;
        check("wrap_empty", empty_out, 4'hF);
        check("wrap_state", state, ST_IDLE);
        read_ctr(3'd4);
        check("wrap_in", counter_out, 5'd1);
        read_ctr(3'd0);
        check("wrap_ch0", counter_out, 5'd9);

        // Asynchronous reset mid-traffic
        push_in = 1'b1; data_in = 12'h005; tick();
        push_in = 1'b0; tick();
        req = 1'b1; idx = 3'd0; tick(); req = 1'b0;
        check("mid_pre_empty", empty_out, 4'b1110);
        check("mid_pre_valid", counter_valid, 1'b1);
        #2 reset = 1'b1;
        #1;
        check("mid_state", state, ST_RESET);
        check("mid_empty", empty_out, 4'hF);
        check("mid_aempty", almost_empty_out, 4'hF);
        check("mid_data", data_out, 48'h0);
        check("mid_cnt", counter_out, 5'd0);
        check("mid_valid", counter_valid, 1'b0);
        check("mid_full", full_in, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/tl_router_param.md
# tl_router_param

Parametrised transaction-layer router: one input FIFO feeds NCH output-channel FIFOs. Each word is steered by a class field inside the word, with per-channel backpressure from programmable almost-full thresholds. The block includes a five-state control FSM with sticky error detection and a bank of readable traffic counters. It is the next-generation replacement for the fixed 4-port, 12-bit transaction-layer top, generalised in word width, FIFO depth and channel count.

## Interface
- WIDTH, 12: data word width in bits.
- DEPTH, 8: entries per FIFO; must be a power of 2 and at least 4.
- NCH, 4: number of output channels; must be a power of 2 and at least 2.
- SEL_LSB, 10: LSB of the channel-select field, which spans data[SEL_LSB +: log2(NCH)].
- CNT_W, 5: width of each traffic counter.
- clk  in  1  sole clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- init  in  1  level; while high the FSM sits in INIT and latches the thresholds.
- Umbral_bajo  in  log2(DEPTH)  almost-empty threshold.
- Umbral_alto  in  log2(DEPTH)  almost-full threshold.
- push_in  in  1  write request into the input FIFO.
- data_in  in  WIDTH  word to write.
- pop_out  in  NCH  per-channel read request.
- data_out  out  NCH*WIDTH  first-word-fall-through head of each channel; channel c occupies [c*WIDTH +: WIDTH].
- empty_out  out  NCH  per-channel empty flag.
- almost_empty_out  out  NCH  per-channel count <= latched Umbral_bajo.
- full_in  out  1  input FIFO full.
- req  in  1  counter read request.
- idx  in  log2(NCH)+1  counter select: 0..NCH-1 selects the channel pop counters; NCH selects the input-accept counter.
- counter_out  out  CNT_W  registered counter value.
- counter_valid  out  1  one-cycle pulse qualifying counter_out.
- state  out  5  one-hot encoding: RESET=00001, INIT=00010, IDLE=00100, ACTIVE=01000, ERROR=10000.

## Operation
- **FSM transitions**
  - RESET: held while reset is high. Moves to INIT on the first edge after reset deasserts.
  - INIT: latches Umbral_bajo and Umbral_alto every cycle. Clears all FIFO pointers and all counters. Moves to IDLE on the first edge with init low.
  - IDLE: entered when all FIFOs are empty. Moves to ACTIVE when any FIFO is non-empty.
  - ACTIVE: returns to IDLE when all FIFOs are empty.
  - init high in IDLE, ACTIVE or ERROR → INIT.
  - ERROR: sticky. Exits only via init (→ INIT) or reset.
- **Error detection**
  - Overflow: push_in while full_in → ERROR. The word is dropped.
  - Underflow: pop_out[c] while empty_out[c] → ERROR. The pop is ignored.
- **Input writes**
  - Accepted in IDLE and ACTIVE when not full.
  - Ignored in RESET, INIT and ERROR; no error is raised for these.
- **Routing**
  - In IDLE or ACTIVE, when the input FIFO is non-empty and destination c (taken from the head word's select field) has almost_full clear: pop the input and push channel c on the same edge.
  - almost_full means count >= latched Umbral_alto.
  - Head-of-line blocking is intended: a stalled head blocks every channel.
  - Routing is halted in ERROR.
- **Output pops**
  - Honoured in IDLE, ACTIVE and ERROR.
  - In ERROR the output FIFOs drain normally.
- **Counters** (all wrap modulo 2^CNT_W)
  - Counter c increments per accepted pop on channel c.
  - Counter NCH increments per accepted push_in.
  - Cleared by reset and by INIT.
- **Counter read**
  - req=1 at edge k → counter_out and counter_valid=1 valid after edge k, for one cycle.
  - idx > NCH returns 0 with valid still asserted.
  - Counter reads are allowed in every state except RESET.
- **Reset values**
  - state=RESET; all empty_out=1; almost_empty_out=1.
  - full_in=0; data_out=0; counter_out=0; counter_valid=0.
  - Latched thresholds=0.

## Timing
- push_in at edge k → word at the input head after k.
- Routed at edge k+1 if unblocked → visible on data_out and empty_out[c]=0 after k+1.
- Minimum latency from input to output: 2 cycles.
- Throughput: one word per cycle in and one routed per cycle. Each channel may push and pop on the same edge with count unchanged.
- Input FIFO at full: an incoming push is rejected even if a route-pop occurs on the same edge.
- Output FIFOs cannot overflow, because routing is gated by almost_full and Umbral_alto <= DEPTH-1.
- Umbral_alto=0 stalls routing indefinitely. This is legal and not an error.
- Asynchronous reset mid-transfer discards all contents immediately.

## Test plan
All scenarios use defaults (WIDTH=12, DEPTH=8, NCH=4, SEL_LSB=10).
- **Basic routing:** reset, then init with Umbral_alto=6, Umbral_bajo=1. Push 0x005, 0x406, 0x807, 0xC08 → after 2 cycles each channel 0..3 heads the matching word; state=ACTIVE. Pop all → IDLE.
- **Backpressure:** 8 words to channel 2 with no pops → channel 2 holds 6; input holds 2; full_in=0. Pop channel 2 once → one more word routed next edge.
- **Head-of-line blocking:** with channel 1 blocked, push 0x400 then 0x001 → 0x001 stays queued behind 0x400; channel 0 remains empty.
- **Overflow:** with Umbral_alto=0, push 9 words → the 9th is dropped; state=ERROR. Output pops still work. init → INIT with counters 0.
- **Counter read:** push 3 to channel 3 and pop 3. req with idx=3 → counter_out=3. idx=4 → 3. idx=7 → 0. counter_valid is 1 for exactly 1 cycle each.
- **Counter wrap:** 33 accepted pushes → counter_out=1 for idx=4.
- **Mid-traffic reset:** assert reset mid-traffic → all outputs at reset values asynchronously, before the next clk edge.
